// File: rtl/uart_capture_pkg.sv
// Shared types and constants for the UART receive capture stage.
package uart_capture_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_capture_fifo.sv
// First-word-fall-through synchronous FIFO; head reads 0 while empty.
module uart_capture_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot being written when full.
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; empty gating on rdata hides
   // stale contents, and an unreset array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchroniser, frame FSM, shifter, error counting and
// a byte FIFO presented on a valid/ready interface.
module uart_rx_capture
   import uart_capture_pkg::*;
#(
   parameter int CLKS_PER_BIT = 32,
   parameter int FIFO_DEPTH   = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx_i,
   input  logic                          rx_en_i,
   input  logic                          clear_i,
   output logic [DATA_BITS-1:0]          data_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          frame_err_o,
   output logic                          overflow_o,
   output logic [7:0]                    err_cnt_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);

   localparam int CW = cnt_width(CLKS_PER_BIT);
   localparam int BW = cnt_width(DATA_BITS);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;

   rx_state_t              state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   brk_q, brk_d;
   logic                   push_req;
   logic                   ferr;

   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '1;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
   end
   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         brk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         brk_q   <= brk_d;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + CW'(1);
      bit_d    = bit_q;
      shift_d  = shift_q;
      brk_d    = brk_q && !rxs;
      push_req = 1'b0;
      ferr     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (rx_en_i && !rxs && !brk_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               if (bit_q == LAST_BIT) state_d = STOP;
               else                   bit_d   = bit_q + BW'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rxs) begin
                  push_req = 1'b1;
               end else begin
                  ferr  = 1'b1;
                  brk_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Disabling aborts silently: no push, no error, counters parked.
      if (!rx_en_i) begin
         state_d  = IDLE;
         cnt_d    = '0;
         bit_d    = '0;
         push_req = 1'b0;
         ferr     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err_o <= 1'b0;
         err_cnt_o   <= '0;
         overflow_o  <= 1'b0;
      end else begin
         frame_err_o <= ferr;
         if (clear_i)                         err_cnt_o <= '0;
         else if (ferr && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
         if (clear_i)                                   overflow_o <= 1'b0;
         else if (push_req && fifo_full && !fifo_pop)   overflow_o <= 1'b1;
      end
   end

   assign valid_o  = !fifo_empty;
   assign fifo_pop = ready_i && !fifo_empty;

   uart_capture_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_i),
      .push  (push_req),
      .wdata (shift_q),
      .pop   (fifo_pop),
      .rdata (data_o),
      .count (count_o),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule
